goldschmidt_ctrl: RTL
=====================

# goldschmidt_ctrl

Control FSM for the Goldschmidt division datapath, directly upstream of `datapath`. It sequences the initial-approximation scaling step, the K-register updates and the refinement multiplies by driving `sel_ND_mux`, `sel_K_mux` and the register load strobes. It exposes a start/busy/done handshake to the surrounding divider top. Each multiply step is split into a setup cycle, in which the selects settle, and a load cycle.

## Interface
- `ITERS`, 3, number of K-refinement iterations after the IA scaling step; legal range 1..15.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it immediately forces reset values.
- `start`  in  1  request a division; sampled only in IDLE and DONE.
- `load_regN`  out  1  strobe: datapath N register captures the multiplier output.
- `load_regD`  out  1  strobe: datapath D register captures the multiplier output.
- `load_regK`  out  1  strobe: datapath K register captures 2 − D.
- `sel_ND_mux`  out  2  00 idle/hold, 01 external N,D as multiplicand, 10 N,D registers as multiplicand, 11 never driven.
- `sel_K_mux`  out  1  0 selects IA as multiplier, 1 selects the K register.
- `busy`  out  1  high while a division is in flight.
- `done`  out  1  one-cycle pulse; datapath `result` is valid in this cycle.
- `iter`  out  4  completed refinement iterations, 0..ITERS.

## Operation
- States: IDLE, SCALE_SU, SCALE_LD, K_LD, ITER_SU, ITER_LD, DONE.
- IDLE: all strobes 0, `sel_ND_mux`=00, `sel_K_mux`=0, `busy`=0. If `start`=1, go to SCALE_SU and clear `iter`.
- SCALE_SU: `sel_ND_mux`=01, `sel_K_mux`=0, no loads. Next: SCALE_LD.
- SCALE_LD: same selects; `load_regN`=`load_regD`=1. Next: K_LD.
- K_LD: `sel_ND_mux`=00, `load_regK`=1. Next: ITER_SU.
- ITER_SU: `sel_ND_mux`=10, `sel_K_mux`=1, no loads. Next: ITER_LD.
- ITER_LD: same selects; `load_regN`=`load_regD`=1; `iter` increments.
  - If `iter` == ITERS−1 before the increment, go to DONE.
  - Otherwise go to K_LD.
- DONE: `done`=1, `busy`=0, selects 00/0, no loads, `iter` holds at ITERS.
  - If `start`=1, go to SCALE_SU and clear `iter` (back-to-back run).
  - Otherwise go to IDLE.
- `busy`=1 in SCALE_SU, SCALE_LD, K_LD, ITER_SU and ITER_LD.
- `start` is ignored while `busy`=1.
- `load_regK` and `load_regN`/`load_regD` are never high in the same cycle.
- Outputs are Moore, decoded from the state register only. `iter` is a registered 4-bit counter.

## Timing
- Reset values: state IDLE; all outputs 0, including `iter`=0.
- Latency: `start` sampled high at edge 0 gives `done` high in cycle 3 + 3·ITERS. For ITERS=3 that is cycle 12.
- Load strobes are each exactly one cycle wide. The selects are stable for the full cycle before and the cycle of every N/D load.
- Per-run strobe counts:
  - `load_regN` and `load_regD`: ITERS+1 pulses each.
  - `load_regK`: ITERS pulses.
- Reset asserted mid-run forces IDLE and zero outputs at once, with no `done`. After reset deasserts, the FSM waits for a new `start`.
- ITERS=1 path: SCALE_SU, SCALE_LD, K_LD, ITER_SU, ITER_LD, DONE; `done` in cycle 6.

## Test plan
- Single run, ITERS=3, `start` pulsed one cycle:
  - `busy` high cycles 1–11, `done` high only in cycle 12, `iter`=3 at DONE.
  - Exact select/strobe sequence: 01/0 then 01/0+N,D load, then K, then 10/1 twice+N,D load interleaved with K, …
- `start` held high for 20 cycles:
  - Second run begins directly from DONE, cycle 13 is SCALE_SU, second `done` in cycle 24.
  - No IDLE cycle between runs; `start` ignored while busy.
- Reset driven low at cycle 7, asynchronously between edges:
  - All outputs 0 immediately and state IDLE.
  - `start` after release gives `done` 12 cycles later.
- ITERS=1 parameter build: `done` in cycle 6; strobe counts N=2, D=2, K=1.
- Strobe checker over 100 random `start` patterns:
  - `load_regK` never overlaps an N/D load.
  - `sel_ND_mux` never 11.
  - Loads never occur in IDLE or DONE.
- With the real `datapath` attached, N=0x0050, D=0x0050 and IA from the reciprocal table: `result` at `done` equals 1.0 in the datapath fixed-point format, within 1 LSB.

Source files
------------

// File: rtl/goldschmidt_ctrl.sv
// Control FSM for the Goldschmidt divider: sequences IA scaling, K updates and
// refinement multiplies, each multiply split into a select-settle and a load cycle.
module goldschmidt_ctrl #(
    parameter int ITERS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       load_regN,
    output logic       load_regD,
    output logic       load_regK,
    output logic [1:0] sel_ND_mux,
    output logic       sel_K_mux,
    output logic       busy,
    output logic       done,
    output logic [3:0] iter,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCALE_SU = 3'd1,
        S_SCALE_LD = 3'd2,
        S_K_LD     = 3'd3,
        S_ITER_SU  = 3'd4,
        S_ITER_LD  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(ITERS - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_load_n;
    logic       r_load_d;
    logic       r_load_k;
    logic [1:0] r_sel_nd;
    logic       r_sel_k;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_iter;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_SCALE_SU;
            S_SCALE_SU: w_next = S_SCALE_LD;
            S_SCALE_LD: w_next = S_K_LD;
            S_K_LD:     w_next = S_ITER_SU;
            S_ITER_SU:  w_next = S_ITER_LD;
            S_ITER_LD:  w_next = (r_iter == LP_LAST) ? S_DONE : S_K_LD;
            S_DONE:     w_next = start ? S_SCALE_SU : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is a pure
    // function of the state register in the cycle it is visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_load_n <= 1'b0;
            r_load_d <= 1'b0;
            r_load_k <= 1'b0;
            r_sel_nd <= 2'b00;
            r_sel_k  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_iter   <= 4'd0;
        end else begin
            r_state  <= w_next;
            r_load_n <= 1'b0;
            r_load_d <= 1'b0;
            r_load_k <= 1'b0;
            r_sel_nd <= 2'b00;
            r_sel_k  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            case (w_next)
                S_SCALE_SU: begin
                    r_sel_nd <= 2'b01;
                    r_busy   <= 1'b1;
                end
                S_SCALE_LD: begin
                    r_sel_nd <= 2'b01;
                    r_load_n <= 1'b1;
                    r_load_d <= 1'b1;
                    r_busy   <= 1'b1;
                end
                S_K_LD: begin
                    r_load_k <= 1'b1;
                    r_busy   <= 1'b1;
                end
                S_ITER_SU: begin
                    r_sel_nd <= 2'b10;
                    r_sel_k  <= 1'b1;
                    r_busy   <= 1'b1;
                end
                S_ITER_LD: begin
                    r_sel_nd <= 2'b10;
                    r_sel_k  <= 1'b1;
                    r_load_n <= 1'b1;
                    r_load_d <= 1'b1;
                    r_busy   <= 1'b1;
                end
                S_DONE:  r_done <= 1'b1;
                default: ;
            endcase
            if (w_next == S_SCALE_SU) begin
                r_iter <= 4'd0;
            end else if (r_state == S_ITER_LD) begin
                r_iter <= r_iter + 4'd1;
            end
        end
    end

    assign load_regN  = r_load_n;
    assign load_regD  = r_load_d;
    assign load_regK  = r_load_k;
    assign sel_ND_mux = r_sel_nd;
    assign sel_K_mux  = r_sel_k;
    assign busy       = r_busy;
    assign done       = r_done;
    assign iter       = r_iter;
    assign dbg_state  = r_state;

endmodule
